sig_buffer_writer: RTL and testbench
====================================

Name: sig_buffer_writer

Overview:
- Arbitrates between two incoming biosignal sample streams (ECG and EMG) and writes them into the shared 4K x 32 signal RAM that the VGA display scans.
- Maintains one circular write region per stream: ECG region at 12'h801, EMG region at 12'hC7F, 512 words each.
- Also sequences freeze (hold the displayed trace) and clear (zero both regions).
- Sits between the acquisition front-end and the RAM write port; the display keeps the read port.

Parameters:
- ECG_BASE, 12'h801, first RAM word of the ECG region
- EMG_BASE, 12'hC7F, first RAM word of the EMG region
- DEPTH, 512, words per region; power of two; pointer width is log2(DEPTH)
- DATA_W, 12, sample width

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ecg_valid  in  1  ECG sample offered
- ecg_data  in  DATA_W  ECG sample, unsigned
- ecg_ready  out  1  ECG sample accepted this cycle when ecg_valid is also high
- emg_valid  in  1  EMG sample offered
- emg_data  in  DATA_W  EMG sample, unsigned
- emg_ready  out  1  EMG sample accepted this cycle when emg_valid is also high
- freeze  in  1  level; while high, no samples are accepted
- clear  in  1  single-cycle pulse; starts zeroing both regions
- mem_we  out  1  RAM write strobe
- mem_addr  out  12  RAM write address
- mem_wdata  out  32  RAM write data
- ecg_ptr  out  9  next ECG write offset (0..DEPTH-1)
- emg_ptr  out  9  next EMG write offset
- ecg_wrapped  out  1  sticky; ECG region has filled at least once
- emg_wrapped  out  1  sticky; EMG region has filled at least once
- busy  out  1  clear sweep in progress

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high.
- Reset values: state=RUN; mem_we=0, mem_addr=0, mem_wdata=0; both pointers 0; both wrapped flags 0; busy=0; round-robin priority=ECG.
- States:
  - RUN: normal arbitration.
  - CLEAR: sweep. Entered from RUN on clear=1.
- RUN readiness and arbitration (combinational):
  - Readies are 0 when freeze=1 or clear=1.
  - Only ECG valid: ecg_ready=1.
  - Only EMG valid: emg_ready=1.
  - Both valid: only the priority holder gets ready.
  - At most one ready is high per cycle.
  - Ready never depends on the other stream's data.
- Priority update on every transfer: priority moves to the stream that did not transfer. Alternation is therefore strict under continuous contention.
- Transfer = valid & ready. Registered write occurs 1 cycle after the transfer:
  - mem_we=1
  - mem_addr = BASE + ptr, 12-bit wrap-free since regions are in range
  - mem_wdata = zero-extended sample in bits [DATA_W-1:0]
- Pointer on transfer: ptr <= ptr+1 mod DEPTH. On 511->0, that stream's wrapped flag sets and stays set until reset or clear.
- mem_we is 0 in any cycle not following a transfer and not in the CLEAR sweep.
- Freeze:
  - Pointers and flags hold.
  - A write already registered from the previous cycle still completes.
  - Upstream holds its samples; no data is dropped inside this block.
- CLEAR sweep:
  - The clear pulse in RUN forces readies low that cycle; clear wins over a simultaneous valid.
  - The next cycle enters CLEAR with busy=1.
  - Writes 0 to ECG_BASE..ECG_BASE+DEPTH-1, then EMG_BASE..EMG_BASE+DEPTH-1, one word per cycle, mem_we=1 throughout: 2*DEPTH=1024 write cycles.
  - Readies are 0 throughout.
  - After the last word: pointers=0, wrapped flags=0, priority=ECG, busy=0, return to RUN.
  - A pending registered sample write from the clear cycle is issued before the sweep begins, so the sweep overwrites it.
- clear while in CLEAR: ignored; the sweep is not restarted.
- freeze during CLEAR: no effect on the sweep.
- Reset mid-CLEAR: aborts immediately to reset values, and mem_we=0 the next cycle. Region contents are undefined, not guaranteed zero.
- Latency: transfer-to-RAM-write is 1 cycle. Throughput is 1 sample/cycle total across both streams.

Test Plan:
- Reset, then ecg_valid=1 with ecg_data=12'hABC for one cycle -> ecg_ready=1; next cycle mem_we=1, mem_addr=12'h801, mem_wdata=32'h00000ABC; ecg_ptr=1.
- Both valid continuously for 6 cycles -> grants ECG, EMG, ECG, EMG, ECG, EMG; EMG writes hit 12'hC7F, C80, C81; ecg_ptr=3, emg_ptr=3.
- 512 ECG samples back-to-back -> last write at 12'hA00; ecg_ptr=0, ecg_wrapped=1; the 513th sample writes 12'h801.
- freeze=1 with both valid for 10 cycles -> both readies 0, no mem_we after the first cycle, pointers unchanged; on release, arbitration resumes with the held priority.
- clear pulse concurrent with ecg_valid -> ecg_ready=0 that cycle; busy=1 for 1024 cycles; writes of 0 cover 12'h801..12'hA00, then 12'hC7F..12'hE7E; afterwards pointers=0 and flags=0.
- reset asserted 100 cycles into a sweep -> next cycle busy=0, mem_we=0, pointers=0; a following valid sample writes to its BASE address.

Source files
------------

// File: rtl/sig_buffer_writer.sv
// Round-robin writer of ECG/EMG sample streams into the shared display RAM,
// with a freeze hold and a clear sweep that zeroes both circular regions.
module sig_buffer_writer #(
    parameter logic [11:0] ECG_BASE = 12'h801,
    parameter logic [11:0] EMG_BASE = 12'hC7F,
    parameter int          DEPTH    = 512,
    parameter int          DATA_W   = 12
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ecg_valid,
    input  logic [DATA_W-1:0]        ecg_data,
    output logic                     ecg_ready,
    input  logic                     emg_valid,
    input  logic [DATA_W-1:0]        emg_data,
    output logic                     emg_ready,
    input  logic                     freeze,
    input  logic                     clear,
    output logic                     mem_we,
    output logic [11:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [$clog2(DEPTH)-1:0] ecg_ptr,
    output logic [$clog2(DEPTH)-1:0] emg_ptr,
    output logic                     ecg_wrapped,
    output logic                     emg_wrapped,
    output logic                     busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {ST_RUN, ST_CLEAR} state_t;

    state_t          state_q, state_d;
    logic            prio_q, prio_d;          // 0: ECG holds priority, 1: EMG
    logic [PW-1:0]   ecg_ptr_q, ecg_ptr_d;
    logic [PW-1:0]   emg_ptr_q, emg_ptr_d;
    logic            ecg_wrap_q, ecg_wrap_d;
    logic            emg_wrap_q, emg_wrap_d;
    logic [CW-1:0]   cnt_q, cnt_d;            // sweep word currently on the write port
    logic            we_q, we_d;
    logic [11:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            ecg_rdy, emg_rdy;

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        ecg_ptr_d  = ecg_ptr_q;
        emg_ptr_d  = emg_ptr_q;
        ecg_wrap_d = ecg_wrap_q;
        emg_wrap_d = emg_wrap_q;
        cnt_d      = cnt_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ecg_rdy    = 1'b0;
        emg_rdy    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (clear) begin
                    // First sweep word is registered now so busy and mem_we rise together.
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    we_d    = 1'b1;
                    addr_d  = ECG_BASE;
                    wdata_d = '0;
                end else if (!freeze) begin
                    if (ecg_valid && (!emg_valid || !prio_q)) begin
                        ecg_rdy = 1'b1;
                    end else if (emg_valid) begin
                        emg_rdy = 1'b1;
                    end

                    if (ecg_rdy) begin
                        we_d      = 1'b1;
                        addr_d    = ECG_BASE + 12'(ecg_ptr_q);
                        wdata_d   = 32'(ecg_data);
                        ecg_ptr_d = ecg_ptr_q + 1'b1;
                        prio_d    = 1'b1;
                        if (ecg_ptr_q == '1) begin
                            ecg_wrap_d = 1'b1;
                        end
                    end else if (emg_rdy) begin
                        we_d      = 1'b1;
                        addr_d    = EMG_BASE + 12'(emg_ptr_q);
                        wdata_d   = 32'(emg_data);
                        emg_ptr_d = emg_ptr_q + 1'b1;
                        prio_d    = 1'b0;
                        if (emg_ptr_q == '1) begin
                            emg_wrap_d = 1'b1;
                        end
                    end
                end
            end

            ST_CLEAR: begin
                if (cnt_q == CW'(2 * DEPTH - 1)) begin
                    state_d    = ST_RUN;
                    prio_d     = 1'b0;
                    ecg_ptr_d  = '0;
                    emg_ptr_d  = '0;
                    ecg_wrap_d = 1'b0;
                    emg_wrap_d = 1'b0;
                end else begin
                    // Top counter bit selects the EMG half of the sweep.
                    cnt_d   = cnt_q + 1'b1;
                    we_d    = 1'b1;
                    wdata_d = '0;
                    addr_d  = cnt_d[PW] ? (EMG_BASE + 12'(cnt_d[PW-1:0]))
                                        : (ECG_BASE + 12'(cnt_d[PW-1:0]));
                end
            end

            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_RUN;
            prio_q     <= 1'b0;
            ecg_ptr_q  <= '0;
            emg_ptr_q  <= '0;
            ecg_wrap_q <= 1'b0;
            emg_wrap_q <= 1'b0;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            ecg_ptr_q  <= ecg_ptr_d;
            emg_ptr_q  <= emg_ptr_d;
            ecg_wrap_q <= ecg_wrap_d;
            emg_wrap_q <= emg_wrap_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign ecg_ready   = ecg_rdy;
    assign emg_ready   = emg_rdy;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign ecg_ptr     = ecg_ptr_q;
    assign emg_ptr     = emg_ptr_q;
    assign ecg_wrapped = ecg_wrap_q;
    assign emg_wrapped = emg_wrap_q;
    assign busy        = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_sig_buffer_writer.sv
// Scoreboard bench for sig_buffer_writer: expected RAM writes are queued by the
// stimulus process and consumed by an independent write-port monitor.
module tb_sig_buffer_writer;

    logic        clock = 1'b0;
    logic        reset;
    logic        ecg_valid, emg_valid, freeze, clear;
    logic [11:0] ecg_data, emg_data;
    logic        ecg_ready, emg_ready, mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  ecg_ptr, emg_ptr;
    logic        ecg_wrapped, emg_wrapped, busy;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [43:0] exp_q[$];

    logic [11:0] t2_addr [6] = '{12'h801, 12'hC7F, 12'h802, 12'hC80, 12'h803, 12'hC81};

    sig_buffer_writer dut (
        .clock(clock), .reset(reset),
        .ecg_valid(ecg_valid), .ecg_data(ecg_data), .ecg_ready(ecg_ready),
        .emg_valid(emg_valid), .emg_data(emg_data), .emg_ready(emg_ready),
        .freeze(freeze), .clear(clear),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .ecg_ptr(ecg_ptr), .emg_ptr(emg_ptr),
        .ecg_wrapped(ecg_wrapped), .emg_wrapped(emg_wrapped), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Write-port monitor
    always @(negedge clock) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", mem_addr, mem_wdata);
            end else begin
                logic [43:0] e;
                e = exp_q.pop_front();
                chk("mem_write", 64'({mem_addr, mem_wdata}), 64'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic ev, input logic [11:0] ed, input logic mv,
                         input logic [11:0] md, input logic fr, input logic cl);
        ecg_valid = ev; ecg_data = ed;
        emg_valid = mv; emg_data = md;
        freeze = fr; clear = cl;
        #3;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ecg_valid = 1'b0; emg_valid = 1'b0; freeze = 1'b0; clear = 1'b0;
        ecg_data = '0; emg_data = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic push_sweep();
        for (int j = 0; j < 1024; j++) begin
            if (j < 512) exp_q.push_back({12'h801 + 12'(j), 32'h0});
            else         exp_q.push_back({12'hC7F + 12'(j - 512), 32'h0});
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        do_reset();

        // Reset state
        drive(0, 12'h0, 0, 12'h0, 0, 0);
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_ptrs", 64'({ecg_ptr, emg_ptr}), 64'(0));
        chk("rst_flags", 64'({ecg_wrapped, emg_wrapped, busy}), 64'(0));
        chk("rst_ready_idle", 64'({ecg_ready, emg_ready}), 64'(0));
        tick();

        // Single ECG sample
        drive(1, 12'hABC, 0, 12'h0, 0, 0);
        chk("t1_ecg_ready", 64'({ecg_ready, emg_ready}), 64'(2'b10));
        exp_q.push_back({12'h801, 32'h00000ABC});
        tick();
        drive(0, 12'h0, 0, 12'h0, 0, 0);
        chk("t1_ecg_ptr", 64'(ecg_ptr), 64'(1));
        tick();

        // Continuous contention alternates strictly
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, 12'h100 + 12'(i), 1, 12'h200 + 12'(i), 0, 0);
            chk("t2_grant", 64'({ecg_ready, emg_ready}), (i % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
            exp_q.push_back({t2_addr[i], (i % 2 == 0) ? 32'(12'h100 + 12'(i)) : 32'(12'h200 + 12'(i))});
            tick();
        end
        drive(0, 12'h0, 0, 12'h0, 0, 0);
        chk("t2_ptrs", 64'({ecg_ptr, emg_ptr}), 64'({9'd3, 9'd3}));
        tick();

        // 512 back-to-back ECG samples, then the wrap
        do_reset();
        for (int i = 0; i < 512; i++) begin
            drive(1, 12'(i), 0, 12'h0, 0, 0);
            chk("t3_ready", 64'(ecg_ready), 64'(1));
            exp_q.push_back({12'h801 + 12'(i), 32'(12'(i))});
            tick();
        end
        drive(1, 12'h5A5, 0, 12'h0, 0, 0);
        chk("t3_ptr_wrapped", 64'(ecg_ptr), 64'(0));
        chk("t3_flags", 64'({ecg_wrapped, emg_wrapped}), 64'(2'b10));
        chk("t3_513_ready", 64'(ecg_ready), 64'(1));
        exp_q.push_back({12'h801, 32'h000005A5});
        tick();

        // Freeze with both streams offering
        for (int i = 0; i < 10; i++) begin
            drive(1, 12'h888, 1, 12'h777, 1, 0);
            chk("t4_frozen_ready", 64'({ecg_ready, emg_ready}), 64'(0));
            tick();
        end
        drive(1, 12'h888, 1, 12'h777, 0, 0);
        chk("t4_ptrs_held", 64'({ecg_ptr, emg_ptr}), 64'({9'd1, 9'd0}));
        chk("t4_resume_emg", 64'({ecg_ready, emg_ready}), 64'(2'b01));
        exp_q.push_back({12'hC7F, 32'h00000777});
        tick();
        drive(1, 12'h888, 1, 12'h777, 0, 0);
        chk("t4_resume_ecg", 64'({ecg_ready, emg_ready}), 64'(2'b10));
        exp_q.push_back({12'h802, 32'h00000888});
        tick();

        // Clear pulse beats a simultaneous valid
        drive(1, 12'h999, 0, 12'h0, 0, 1);
        chk("t5_clear_ready", 64'({ecg_ready, emg_ready}), 64'(0));
        push_sweep();
        tick();
        n = 0;
        while (busy === 1'b1 && n < 1100) begin
            n++;
            ecg_valid = (n >= 40 && n < 55);
            emg_valid = ecg_valid;
            clear     = (n == 50);
            freeze    = (n >= 60 && n < 70);
            if (n == 50) begin
                #3;
                chk("t5_ready_in_sweep", 64'({ecg_ready, emg_ready}), 64'(0));
            end
            tick();
        end
        drive(1, 12'h123, 1, 12'h456, 0, 0);
        chk("t5_busy_cycles", 64'(n), 64'(1024));
        chk("t5_ptrs_zero", 64'({ecg_ptr, emg_ptr}), 64'(0));
        chk("t5_flags_zero", 64'({ecg_wrapped, emg_wrapped, busy}), 64'(0));
        chk("t5_prio_ecg", 64'({ecg_ready, emg_ready}), 64'(2'b10));
        exp_q.push_back({12'h801, 32'h00000123});
        tick();

        // Reset in the middle of a sweep
        drive(0, 12'h0, 0, 12'h0, 0, 1);
        push_sweep();
        tick();
        clear = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        reset = 1'b1;
        tick();
        exp_q.delete();
        reset = 1'b0;
        #3;
        chk("t6_busy", 64'(busy), 64'(0));
        chk("t6_mem_we", 64'(mem_we), 64'(0));
        chk("t6_ptrs", 64'({ecg_ptr, emg_ptr}), 64'(0));
        tick();
        drive(0, 12'h0, 1, 12'h3C3, 0, 0);
        chk("t6_emg_ready", 64'({ecg_ready, emg_ready}), 64'(2'b01));
        exp_q.push_back({12'hC7F, 32'h000003C3});
        tick();
        drive(0, 12'h0, 0, 12'h0, 0, 0);
        tick(); tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
